// File: rtl/ripple_count_sampler_if.sv
// Output stream of the ripple count sampler: settled count, wrap count,
// valid/ready handshake and the sticky overrun flag.
interface ripple_count_sampler_if #(
    parameter int WIDTH     = 4,
    parameter int EXT_WIDTH = 4
);
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_count;
    logic [EXT_WIDTH-1:0] out_wraps;
    logic                 overrun;

    modport master (
        output out_valid,
        output out_count,
        output out_wraps,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_count,
        input  out_wraps,
        input  overrun,
        output out_ready
    );
endinterface

// File: rtl/ripple_count_sampler.sv
// Synchronizes an asynchronous ripple counter, rejects transient codes and
// emits each settled new value once, tagged with a rollover count.
module ripple_count_sampler #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int EXT_WIDTH     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            cnt_in,
    ripple_count_sampler_if.master      out
);

    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]     s2_sync;

    logic [WIDTH-1:0]     cand_reg,    cand_next;
    logic [STAB_W-1:0]    stab_reg,    stab_next;
    logic [WIDTH-1:0]     cur_reg,     cur_next;
    logic [EXT_WIDTH-1:0] wraps_reg,   wraps_next;
    logic [WIDTH-1:0]     count_reg,   count_next;
    logic [EXT_WIDTH-1:0] owraps_reg,  owraps_next;
    logic                 valid_reg,   valid_next;
    logic                 overrun_reg, overrun_next;

    logic accept;
    logic slot_free;

    // Two-flop synchronizer per bit; the ripple bits settle independently,
    // so multi-bit coherence is left to the stability filter below.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sync
            logic s1_bit_reg;
            logic s2_bit_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_bit_reg <= 1'b0;
                    s2_bit_reg <= 1'b0;
                end else begin
                    s1_bit_reg <= cnt_in[gi];
                    s2_bit_reg <= s1_bit_reg;
                end
            end

            assign s2_sync[gi] = s2_bit_reg;
        end
    endgenerate

    always_comb begin
        cand_next    = cand_reg;
        stab_next    = stab_reg;
        cur_next     = cur_reg;
        wraps_next   = wraps_reg;
        count_next   = count_reg;
        owraps_next  = owraps_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;

        // Candidate restarts its stability run whenever the sample changes.
        if (s2_sync != cand_reg) begin
            cand_next = s2_sync;
            stab_next = '0;
        end else if (stab_reg != STAB_MAX) begin
            stab_next = stab_reg + 1'b1;
        end

        accept    = (s2_sync == cand_reg) && (stab_reg == STAB_MAX) && (cand_reg != cur_reg);
        slot_free = !valid_reg || out.out_ready;

        if (accept) begin
            cur_next = cand_reg;
            if (cand_reg < cur_reg) begin
                wraps_next = wraps_reg + 1'b1;
            end
            // A full slot keeps its beat; cur and wraps still advance so the
            // next delivered beat carries the correct cumulative state.
            if (slot_free) begin
                count_next  = cand_reg;
                owraps_next = wraps_next;
                valid_next  = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (out.out_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_reg    <= '0;
            stab_reg    <= '0;
            cur_reg     <= '0;
            wraps_reg   <= '0;
            count_reg   <= '0;
            owraps_reg  <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            cand_reg    <= cand_next;
            stab_reg    <= stab_next;
            cur_reg     <= cur_next;
            wraps_reg   <= wraps_next;
            count_reg   <= count_next;
            owraps_reg  <= owraps_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    assign out.out_valid = valid_reg;
    assign out.out_count = count_reg;
    assign out.out_wraps = owraps_reg;
    assign out.overrun   = overrun_reg;

endmodule
